// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bridge FSM states, load/store opcodes and the
// read-data fill pattern returned when a bus transfer is abandoned.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_bridge_state_t;

  localparam logic [5:0]  OP_LW        = 6'b100011;
  localparam logic [5:0]  OP_SW        = 6'b101011;
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

endpackage

// File: rtl/data_mem_bridge_if.sv
// CPU memory-stage request port plus Avalon-MM-style master bus, bundled for
// the data memory bridge. master = bridge side, slave = CPU/bus environment.
interface data_mem_bridge_if;

  logic        cpu_memread;
  logic        cpu_memwrite;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic        bus_waitrequest;
  logic [31:0] bus_readdata;

  modport master (
    input  cpu_memread, cpu_memwrite, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    output bus_address, bus_read, bus_write, bus_writedata, bus_byteenable,
    input  bus_waitrequest, bus_readdata
  );

  modport slave (
    output cpu_memread, cpu_memwrite, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    input  bus_address, bus_read, bus_write, bus_writedata, bus_byteenable,
    output bus_waitrequest, bus_readdata
  );

endinterface

// File: rtl/data_mem_bridge_wait_counter.sv
// 8-bit wait-cycle counter with synchronous clear; tc flags the cycle in which
// the TERMINAL-th enabled cycle is being counted.
module wait_counter #(
  parameter logic [7:0] TERMINAL = 8'd255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign tc = en && (count_q == TERMINAL - 8'd1);

endmodule

// File: rtl/data_mem_bridge.sv
// Bridges CPU lw/sw requests to single-word Avalon-MM transfers, stalling the core.
// Optional waitrequest timeout abort enabled by DATA_MEM_BRIDGE_TIMEOUT_EN.
module data_mem_bridge
  import cpu_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_bridge_if.master mif,
  output logic              mem_error
);

  mem_bridge_state_t state_q, state_d;
  logic req;
  logic misaligned;
  logic abort;

  assign req           = mif.cpu_memread | mif.cpu_memwrite;
  assign misaligned    = (mif.cpu_addr[1:0] != 2'b00);
  assign mif.cpu_stall = req && (state_q != DONE);

`ifdef DATA_MEM_BRIDGE_TIMEOUT_EN
  logic wait_tc;

  wait_counter #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != ACCESS),
    .en    ((state_q == ACCESS) && mif.bus_waitrequest),
    .tc    (wait_tc)
  );

  assign abort = wait_tc;
`else
  logic [7:0] timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES;
  assign abort          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = misaligned ? DONE : ACCESS;
      ACCESS:  if (!mif.bus_waitrequest || abort) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are only loaded on entry to ACCESS and cleared on leaving it,
  // so they stay stable for the whole waited transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= IDLE;
      mif.bus_address    <= '0;
      mif.bus_read       <= 1'b0;
      mif.bus_write      <= 1'b0;
      mif.bus_writedata  <= '0;
      mif.bus_byteenable <= '0;
      mif.cpu_rdata      <= '0;
      mem_error          <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (misaligned) begin
              mem_error <= 1'b1;
              if (!mif.cpu_memwrite) mif.cpu_rdata <= '0;
            end else begin
              mif.bus_address    <= {mif.cpu_addr[31:2], 2'b00};
              mif.bus_writedata  <= mif.cpu_wdata;
              mif.bus_write      <= mif.cpu_memwrite;
              mif.bus_read       <= !mif.cpu_memwrite;
              mif.bus_byteenable <= 4'hF;
            end
          end
        end
        ACCESS: begin
          if (!mif.bus_waitrequest) begin
            if (mif.bus_read) mif.cpu_rdata <= mif.bus_readdata;
            mif.bus_read       <= 1'b0;
            mif.bus_write      <= 1'b0;
            mif.bus_byteenable <= '0;
          end else if (abort) begin
            if (mif.bus_read) mif.cpu_rdata <= TIMEOUT_FILL;
            mem_error          <= 1'b1;
            mif.bus_read       <= 1'b0;
            mif.bus_write      <= 1'b0;
            mif.bus_byteenable <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/data_mem_bridge.md
# data_mem_bridge

Responder for the CPU's `memread`/`memwrite` data-memory requests, as issued for `lw`/`sw`. It turns each request into a single word transfer on an Avalon-MM-style master port with `waitrequest`. It stalls the core until the transfer completes and returns read data. It sits between the datapath's memory stage and the data bus.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum consecutive `bus_waitrequest` cycles before abort. Width is 8 bits; legal range is 1–255.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_memread`  in  1  word read request; held by the CPU until `cpu_stall` is low.
- `cpu_memwrite`  in  1  word write request; held the same way.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data; valid in the cycle `cpu_stall` falls after a read.
- `cpu_stall`  out  1  freezes the pipeline while a request is outstanding.
- `bus_address`  out  32  word-aligned address, registered.
- `bus_read`  out  1  registered read strobe.
- `bus_write`  out  1  registered write strobe.
- `bus_writedata`  out  32  registered store data.
- `bus_byteenable`  out  4  always 4'b1111 while a strobe is high, else 0.
- `bus_waitrequest`  in  1  slave not ready.
- `bus_readdata`  in  32  valid in a cycle with `bus_read && !bus_waitrequest`.
- `mem_error`  out  1  sticky error flag, cleared only by reset.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On `cpu_memread|cpu_memwrite`, latch address, data and direction, then go to ACCESS.
  - If both requests are high, the write wins.
  - If `cpu_addr[1:0]!=0`, set `mem_error`, issue no bus strobe and go directly to DONE. `cpu_rdata` is 0 for such a read.
- ACCESS:
  - Hold `bus_read` or `bus_write` and all bus outputs stable.
  - On `!bus_waitrequest`, capture `bus_readdata` into `cpu_rdata` (reads only), drop the strobe and go to DONE.
- DONE:
  - `cpu_stall`=0 for exactly one cycle, then return to IDLE.
  - A new request in the following IDLE cycle starts a fresh transfer; there is no back-to-back pipelining.
- `cpu_stall` is combinational: (`cpu_memread|cpu_memwrite`) && state!=DONE.
- `cpu_rdata` holds its last value until the next read completes.
- A request dropped by the CPU while in ACCESS does not abort the transfer. The bridge completes it, passes through DONE and returns to IDLE.

## Timing
- Reset values:
  - state=IDLE.
  - `bus_read`=`bus_write`=0.
  - `bus_address`=`bus_writedata`=0.
  - `bus_byteenable`=0.
  - `cpu_rdata`=0.
  - `mem_error`=0.
  - `cpu_stall` follows its combinational definition.
- Zero-wait latency: request seen in cycle N; strobe high in N+1; `cpu_stall` low in N+2. The minimum stall is 2 cycles.
- Each cycle of `bus_waitrequest` adds one cycle of stall.
- Reset asserted mid-ACCESS drops the strobes immediately (asynchronously); the transfer is lost.
- Strobes are never high in IDLE or DONE.

## Configuration
- `DATA_MEM_BRIDGE_TIMEOUT_EN` defined:
  - An 8-bit wait counter runs in ACCESS and is cleared on entering ACCESS.
  - When it reaches `TIMEOUT_CYCLES` with `bus_waitrequest` still high, the bridge drops the strobe, sets `mem_error`, writes `cpu_rdata`=32'hDEADBEEF for reads and goes to DONE.
- Undefined: no counter exists; ACCESS waits indefinitely and `mem_error` reports misalignment only.

## Structure
- Shared package `cpu_pkg` holds:
  - `mem_bridge_state_t` (IDLE/ACCESS/DONE).
  - Opcode constants `OP_LW`=6'b100011 and `OP_SW`=6'b101011.
  - `TIMEOUT_FILL`=32'hDEADBEEF.
- One sub-module, `wait_counter`: a clear/enable/terminal-count counter, instantiated only under `DATA_MEM_BRIDGE_TIMEOUT_EN`.

## Test plan
- **Zero-wait read:** read @0x100, `bus_waitrequest`=0, `bus_readdata`=0x12345678 → `bus_read` high 1 cycle, `cpu_stall` high 2 cycles, `cpu_rdata`=0x12345678.
- **Write with waits:** write 0xCAFEF00D @0x204, 3 wait cycles → `bus_write`, address and data stable for 4 cycles; stall 5 cycles; `mem_error`=0.
- **Misaligned read:** read @0x102 → no strobe, stall 1 cycle, `mem_error`=1 and stays 1.
- **Simultaneous requests:** read+write @0x10 → only `bus_write` is issued.
- **Timeout:** with `TIMEOUT_CYCLES`=4 and the macro defined, waitrequest held high → abort after 4 wait cycles, `cpu_rdata`=0xDEADBEEF, `mem_error`=1.
- **Reset mid-ACCESS:** reset during a waited read → strobes drop in the same cycle, all outputs return to reset values, and the next read completes normally.
